// File: rtl/cmd_encod_linear_split.sv
// cmd_encod_linear_split: splits a linear burst request into chunks
// bounded by row end and max transfer size, one encoder command each.
module cmd_encod_linear_split #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6,
  parameter int TOTAL_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      mrst_n,
  input  logic                      req_start,
  input  logic [2:0]                req_bank,
  input  logic [ADDRESS_NUMBER-1:0] req_row,
  input  logic [COLADDR_NUMBER-4:0] req_col,
  input  logic [TOTAL_BITS-1:0]     req_num,
  input  logic                      req_skip,
  input  logic                      abort,
  output logic                      start,
  output logic [2:0]                bank_out,
  output logic [ADDRESS_NUMBER-1:0] row_out,
  output logic [COLADDR_NUMBER-4:0] start_col,
  output logic [NUM_XFER_BITS-1:0]  num128_out,
  output logic                      skip_next_page_out,
  input  logic                      enc_done,
  output logic                      busy,
  output logic                      done
);

  localparam int CW  = COLADDR_NUMBER - 3;
  localparam int RW  = CW + 1;
  localparam int XW  = NUM_XFER_BITS + 1;
  localparam int MW0 = (TOTAL_BITS > RW) ? TOTAL_BITS : RW;
  localparam int MW  = (MW0 > XW) ? MW0 : XW;

  localparam logic [MW-1:0] ROW_LEN  = MW'(1) << CW;
  localparam logic [MW-1:0] MAX_XFER = MW'(1) << NUM_XFER_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT
  } state_t;

  state_t                    state_q;
  logic [2:0]                lat_bank_q;
  logic                      lat_skip_q;
  logic [ADDRESS_NUMBER-1:0] cur_row_q;
  logic [CW-1:0]             cur_col_q;
  logic [TOTAL_BITS-1:0]     rem_q;
  logic [MW-1:0]             chunk_q;
  logic                      abort_q;

  logic                      start_q;
  logic                      done_q;
  logic                      busy_q;
  logic [2:0]                bank_q;
  logic [ADDRESS_NUMBER-1:0] row_q;
  logic [CW-1:0]             scol_q;
  logic [NUM_XFER_BITS-1:0]  num_q;
  logic                      skip_q;

  logic [MW-1:0]             rem_w;
  logic [MW-1:0]             room_w;
  logic [MW-1:0]             chunk_w;
  logic                      last_w;
  logic [TOTAL_BITS-1:0]     rem_d;
  logic [RW-1:0]             col_sum;
  logic                      stop_w;

  // Chunk = min(remaining, max transfer, room left in the row).
  always_comb begin
    rem_w   = MW'(rem_q);
    room_w  = ROW_LEN - MW'(cur_col_q);
    chunk_w = rem_w;
    if (chunk_w > MAX_XFER) chunk_w = MAX_XFER;
    if (chunk_w > room_w)   chunk_w = room_w;
    last_w  = (chunk_w == rem_w);
  end

  assign rem_d   = rem_q - TOTAL_BITS'(chunk_q);
  assign col_sum = RW'(cur_col_q) + RW'(chunk_q);
  assign stop_w  = abort_q | abort;

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q    <= IDLE;
      lat_bank_q <= '0;
      lat_skip_q <= 1'b0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      abort_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      scol_q     <= '0;
      num_q      <= '0;
      skip_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q != IDLE) abort_q <= abort_q | abort;
      unique case (state_q)
        IDLE: begin
          if (req_start) begin
            lat_bank_q <= req_bank;
            lat_skip_q <= req_skip;
            cur_row_q  <= req_row;
            cur_col_q  <= req_col;
            rem_q      <= req_num;
            abort_q    <= 1'b0;
            if (req_num == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          chunk_q <= chunk_w;
          bank_q  <= lat_bank_q;
          row_q   <= cur_row_q;
          scol_q  <= cur_col_q;
          num_q   <= chunk_w[NUM_XFER_BITS-1:0];
          skip_q  <= last_w ? lat_skip_q : 1'b1;
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (enc_done) begin
            rem_q     <= rem_d;
            cur_col_q <= col_sum[CW-1:0];
            if (col_sum[CW]) cur_row_q <= cur_row_q + 1'b1;
            if ((rem_d != '0) && !stop_w) begin
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start              = start_q;
  assign done               = done_q;
  assign busy               = busy_q;
  assign bank_out           = bank_q;
  assign row_out            = row_q;
  assign start_col          = scol_q;
  assign num128_out         = num_q;
  assign skip_next_page_out = skip_q;

endmodule

// File: doc/cmd_encod_linear_split.md
CMD_ENCOD_LINEAR_SPLIT -- requirements
Module: cmd_encod_linear_split

Interface
REQ-001 The block SHALL have parameter ADDRESS_NUMBER, default 15, giving the row address width.
REQ-002 The block SHALL have parameter COLADDR_NUMBER, default 10, giving the column address width; a row holds 2^(COLADDR_NUMBER-3) bursts.
REQ-003 The block SHALL have parameter NUM_XFER_BITS, default 6, giving the per-chunk length field width; the maximal chunk is 2^NUM_XFER_BITS bursts, encoded as 0.
REQ-004 The block SHALL have parameter TOTAL_BITS, default 16, giving the total request length width in bursts.
REQ-005 The block SHALL have these ports: clk in 1, the single clock; mrst_n in 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have these request ports: req_start in 1, request pulse; req_bank in 3; req_row in ADDRESS_NUMBER; req_col in COLADDR_NUMBER-3, start column in bursts; req_num in TOTAL_BITS, total bursts; req_skip in 1, skip_next_page for the final chunk; abort in 1.
REQ-007 The block SHALL have these encoder-side ports: start out 1; bank_out out 3; row_out out ADDRESS_NUMBER; start_col out COLADDR_NUMBER-3; num128_out out NUM_XFER_BITS; skip_next_page_out out 1; enc_done in 1, chunk finished.
REQ-008 The block SHALL have these status ports: busy out 1 and done out 1, a 1-cycle pulse.

Function
REQ-009 The state machine SHALL have the states IDLE, CALC, ISSUE and WAIT.
REQ-010 In IDLE, req_start SHALL latch all req_* inputs and the machine SHALL go to CALC, or to IDLE with a done pulse on the next cycle when req_num==0.
REQ-011 While not in IDLE, req_start SHALL be ignored.
REQ-012 In CALC, the chunk length SHALL be registered as min(remaining, 2^NUM_XFER_BITS, 2^(COLADDR_NUMBER-3) - current column), and the machine SHALL go to ISSUE.
REQ-013 In ISSUE, start SHALL be asserted for exactly one cycle with bank_out, row_out, start_col, num128_out (the chunk length modulo 2^NUM_XFER_BITS) and skip_next_page_out valid; the machine SHALL then go to WAIT.
REQ-014 bank_out, row_out, start_col, num128_out and skip_next_page_out SHALL be held stable from ISSUE until the next CALC.
REQ-015 skip_next_page_out SHALL be 1 for every chunk except the final one, and SHALL equal the latched req_skip for the final chunk.
REQ-016 On enc_done in WAIT, remaining SHALL be decremented by the chunk length and the column advanced by it.
REQ-017 When the column reaches the row end it SHALL wrap to 0 and the row SHALL increment modulo 2^ADDRESS_NUMBER; bank never changes.
REQ-018 On enc_done in WAIT, the machine SHALL go to CALC if remaining is non-zero and abort has not been seen, and otherwise to IDLE with done pulsed on the next cycle.
REQ-019 abort SHALL be sampled in any non-IDLE state and remembered; the current chunk always completes, with no new start after it.
REQ-020 enc_done outside WAIT SHALL be ignored.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Latency SHALL be: req_start at cycle N gives start at N+2; enc_done at cycle M gives the next start at M+2 or done at M+1.
REQ-023 The chunk calculation SHALL be full-width with no truncation; remaining SHALL never underflow.

Reset
REQ-024 Asserting mrst_n low SHALL immediately force IDLE and clear start, done, busy, bank_out, row_out, start_col, num128_out, skip_next_page_out, remaining and the abort flag.
REQ-025 Deassertion of mrst_n SHALL be synchronised externally; reset asserted mid-transfer SHALL abandon the request without a done pulse.

Verification
REQ-026 The bench SHALL cover: req_row=5, req_col=0, req_num=200, req_skip=0 -> four starts (row5 col0 num128=0; row5 col64 num128=0; row6 col0 num128=0; row6 col64 num128=8), with skip_next_page_out 1,1,1,0, then one done pulse.
REQ-027 The bench SHALL cover: req_col=120, req_num=10 -> two starts (col120 num128=8; row+1 col0 num128=2).
REQ-028 The bench SHALL cover: req_row=0x7FFF, req_col=127, req_num=2 -> row 0x7FFF col127 num128=1, then row 0x0000 col0 num128=1.
REQ-029 The bench SHALL cover: req_num=0 -> no start pulse, done one cycle after req_start, busy stays 0; and req_start during WAIT -> ignored, latched values unchanged.
REQ-030 The bench SHALL cover: abort during the second chunk of req_num=200 -> that chunk completes, then done with no third start; and mrst_n low during WAIT -> all outputs 0 at once, and no done pulse.
